// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch
// redirect, and the valid/ready instruction stream towards decode.
//   master : fetch_unit side (drives imem_addr/imem_en and the instr_* stream)
//   slave  : memory/decode/branch side
interface fetch_unit_if #(
  parameter int word_size  = 32,
  parameter int addr_width = 5
);
  logic [addr_width-1:0] imem_addr;
  logic                  imem_en;
  logic [word_size-1:0]  imem_rdata;
  logic                  branch_valid;
  logic [addr_width-1:0] branch_target;
  logic [word_size-1:0]  instr_out;
  logic [addr_width-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output imem_addr, imem_en,
    input  imem_rdata,
    input  branch_valid, branch_target,
    output instr_out, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_addr, imem_en,
    output imem_rdata,
    output branch_valid, branch_target,
    input  instr_out, instr_pc, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues one-cycle-latency
// instruction memory reads, buffers returning words in a 2-entry FIFO and
// hands them to decode over valid/ready. Branch redirect flushes the FIFO
// and drops the response in flight.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master (imem request/response, branch, decode stream)
module fetch_unit #(
  parameter int          word_size  = 32,
  parameter int          addr_width = 5,
  parameter int unsigned reset_pc   = 0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [addr_width-1:0] fetch_pc;
  logic [addr_width-1:0] inflight_pc;
  logic                  inflight;
  logic [1:0]            count;
  logic [word_size-1:0]  buf_instr [2];
  logic [addr_width-1:0] buf_pc    [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] used;

  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr_out   = buf_instr[0];
  assign bus.instr_pc    = buf_pc[0];

  assign pop  = bus.instr_valid & bus.instr_ready;
  assign push = inflight & ~bus.branch_valid;

  // Slots already committed after this cycle's pop; pop never exceeds count.
  assign used  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue = ~rst & (bus.branch_valid | (used < 3'd2));

  assign bus.imem_addr = bus.branch_valid ? bus.branch_target : fetch_pc;
  assign bus.imem_en   = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= addr_width'(reset_pc);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= bus.imem_addr + 1'b1;
        inflight_pc <= bus.imem_addr;
      end

      if (bus.branch_valid) begin
        count <= '0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            // Credit rule guarantees count < 2 here.
            buf_instr[count[0]] <= bus.imem_rdata;
            buf_pc[count[0]]    <= inflight_pc;
            count               <= count + 2'd1;
          end
          2'b01: begin
            buf_instr[0] <= buf_instr[1];
            buf_pc[0]    <= buf_pc[1];
            count        <= count - 2'd1;
          end
          2'b11: begin
            // Simultaneous push/pop: shift and refill, count unchanged.
            if (count == 2'd1) begin
              buf_instr[0] <= bus.imem_rdata;
              buf_pc[0]    <= inflight_pc;
            end else begin
              buf_instr[0] <= buf_instr[1];
              buf_pc[0]    <= buf_pc[1];
              buf_instr[1] <= bus.imem_rdata;
              buf_pc[1]    <= inflight_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each vector is one clock cycle with its
// inputs and the hand-computed outputs expected during that cycle.
// Memory word k holds 32'hA000_0000 + k.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.word_size(32), .addr_width(5)) bus ();

  fetch_unit #(.word_size(32), .addr_width(5), .reset_pc(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 1-cycle-latency instruction memory.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'hA000_0000 + {27'b0, bus.imem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, check outputs, advance one clock.
  task automatic vec(input int c, input logic r, input logic rdy, input logic bv,
                     input int bt, input logic ev, input int epc,
                     input logic een, input int eaddr);
    rst               = r;
    bus.instr_ready   = rdy;
    bus.branch_valid  = bv;
    bus.branch_target = 5'(bt);
    #1;
    check($sformatf("c%0d valid", c), {31'b0, bus.instr_valid}, {31'b0, ev});
    if (ev) begin
      check($sformatf("c%0d pc", c), {27'b0, bus.instr_pc}, epc);
      check($sformatf("c%0d instr", c), bus.instr_out, 32'hA000_0000 + epc);
    end
    check($sformatf("c%0d en", c), {31'b0, bus.imem_en}, {31'b0, een});
    if (een) check($sformatf("c%0d addr", c), {27'b0, bus.imem_addr}, eaddr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_ready   = 1'b1;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.imem_rdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst out", bus.instr_out, 32'h0);
    check("rst pc", {27'b0, bus.instr_pc}, 0);
    check("rst addr", {27'b0, bus.imem_addr}, 0);
    vec(-1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Streaming from reset_pc
    vec(0, 0, 1, 0, 0, 0, 0, 1, 0);
    vec(1, 0, 1, 0, 0, 0, 0, 1, 1);
    vec(2, 0, 1, 0, 0, 1, 0, 1, 2);
    // Backpressure for 5 cycles: buffer fills, head holds pc 1
    vec(3, 0, 0, 0, 0, 1, 1, 0, 3);
    for (int c = 4; c < 8; c++) vec(c, 0, 0, 0, 0, 1, 1, 0, 3);
    vec(8, 0, 1, 0, 0, 1, 1, 1, 3);
    vec(9, 0, 1, 0, 0, 1, 2, 1, 4);
    vec(10, 0, 1, 0, 0, 1, 3, 1, 5);
    vec(11, 0, 1, 0, 0, 1, 4, 1, 6);
    // Fill buffer, then branch to 20 while stalled
    vec(12, 0, 0, 0, 0, 1, 5, 0, 7);
    vec(13, 0, 0, 1, 20, 1, 5, 1, 20);
    vec(14, 0, 0, 0, 0, 0, 0, 1, 21);
    vec(15, 0, 1, 0, 0, 1, 20, 1, 22);
    vec(16, 0, 1, 0, 0, 1, 21, 1, 23);
    vec(17, 0, 1, 0, 0, 1, 22, 1, 24);
    // Run across the 31 -> 0 wrap
    for (int c = 18; c < 29; c++) vec(c, 0, 1, 0, 0, 1, (c + 5) % 32, 1, (c + 7) % 32);
    // Reset with a full buffer
    vec(29, 0, 0, 0, 0, 1, 2, 0, 4);
    vec(30, 1, 0, 0, 0, 1, 2, 0, 4);
    vec(31, 0, 1, 0, 0, 0, 0, 1, 0);
    vec(32, 0, 1, 0, 0, 0, 0, 1, 1);
    vec(33, 0, 1, 0, 0, 1, 0, 1, 2);
    vec(34, 0, 1, 0, 0, 1, 1, 1, 3);
    vec(35, 0, 1, 0, 0, 1, 2, 1, 4);
    // Branch to 7 while head pc 3 is being accepted
    vec(36, 0, 1, 1, 7, 1, 3, 1, 7);
    vec(37, 0, 1, 0, 0, 0, 0, 1, 8);
    vec(38, 0, 1, 0, 0, 1, 7, 1, 9);
    vec(39, 0, 1, 0, 0, 1, 8, 1, 10);
    // Back-to-back branches: only target 25 survives
    vec(40, 0, 1, 1, 12, 1, 9, 1, 12);
    vec(41, 0, 1, 1, 25, 0, 0, 1, 25);
    vec(42, 0, 1, 0, 0, 0, 0, 1, 26);
    vec(43, 0, 1, 0, 0, 1, 25, 1, 27);
    vec(44, 0, 1, 0, 0, 1, 26, 1, 28);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
